// File: rtl/result_presenter.sv
// result_presenter: registered LED / 7-segment presentation FSM for training progress and O/X classification results.
module result_presenter #(
  parameter int N_LED   = 8,
  parameter int CLK_HZ  = 50_000_000,
  parameter int DONE_MS = 3000,
  parameter int HOLD_MS = 2000,
  parameter int ANIM_MS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             training_active,
  input  logic             training_done,
  input  logic [7:0]       current_epoch,
  input  logic             btn_submit,
  input  logic             nn_y,
  input  logic [6:0]       nn_o_prob_pct,
  input  logic [15:0]      input_display,
  input  logic             input_valid,
  output logic [N_LED-1:0] led,
  output logic [15:0]      seg_data,
  output logic             seg_valid,
  output logic             seg_number_mode,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {IDLE, TRAIN, DONE, RESULT} st_t;
  localparam longint T_DONE = longint'(DONE_MS) * CLK_HZ / 1000;
  localparam longint T_HOLD = longint'(HOLD_MS) * CLK_HZ / 1000;
  localparam longint T_ANIM = longint'(ANIM_MS) * CLK_HZ / 1000;
  localparam int DW = $clog2(T_DONE + 1);
  localparam int HW = $clog2(T_HOLD + 1);
  localparam int AW = $clog2(T_ANIM + 1);
  localparam logic [DW-1:0] D_LAST = DW'(T_DONE - 1);
  localparam logic [HW-1:0] H_LAST = HW'(T_HOLD - 1);
  localparam logic [AW-1:0] A_LAST = AW'(T_ANIM - 1);

  st_t st, st_n;
  logic ta_s, done_s, done_p, sub_s, sub_p, done_rise, sub_rise;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [AW-1:0] acnt, acnt_n;
  logic [N_LED-1:0] anim, anim_n, led_n;
  logic y_l, y_n, sv_n, nm_n;
  logic [6:0] p_l, p_n, p_in;
  logic [15:0] seg_n;

  function automatic logic [15:0] bcd(input logic [7:0] v);
    return {4'd0, 4'(v / 8'd100), 4'((v / 8'd10) % 8'd10), 4'(v % 8'd10)};
  endfunction

  function automatic logic [N_LED-2:0] bar(input logic [6:0] p);
    int k;
    k = int'(p) * (N_LED - 1) / 100;
    k = (k < 1) ? 1 : k;
    bar = '0;
    for (int i = 0; i < N_LED - 1; i++) bar[i] = (i < k);
  endfunction

  assign done_rise = done_s & ~done_p;
  assign sub_rise  = sub_s & ~sub_p;
  assign p_in      = (nn_o_prob_pct > 7'd100) ? 7'd100 : nn_o_prob_pct;
  assign state     = st;

  always_comb begin
    st_n   = st;
    dcnt_n = dcnt;
    hcnt_n = hcnt;
    acnt_n = acnt;
    anim_n = anim;
    y_n    = y_l;
    p_n    = p_l;
    if (done_rise) begin
      st_n   = DONE;
      dcnt_n = '0;
    end else if (ta_s && st != DONE) begin
      st_n = TRAIN;
      if (st != TRAIN) begin
        anim_n = N_LED'(1);
        acnt_n = '0;
      end else if (acnt == A_LAST) begin
        acnt_n = '0;
        anim_n = {anim[N_LED-2:0], anim[N_LED-1]};
      end else acnt_n = acnt + 1'b1;
    end else if (sub_rise && (st == IDLE || st == RESULT)) begin
      st_n   = RESULT;
      y_n    = nn_y;
      p_n    = p_in;
      hcnt_n = '0;
    end else if (st == DONE) begin
      if (dcnt == D_LAST) begin
        st_n   = ta_s ? TRAIN : IDLE;
        anim_n = N_LED'(1);
        acnt_n = '0;
      end else dcnt_n = dcnt + 1'b1;
    end else if (st == TRAIN) st_n = IDLE;
    else if (st == RESULT) begin
      if (sub_s) hcnt_n = '0;
      else if (hcnt == H_LAST) st_n = IDLE;
      else hcnt_n = hcnt + 1'b1;
    end
    led_n = (st_n == TRAIN)  ? anim_n :
            (st_n == DONE)   ? '1 :
            (st_n == RESULT) ? {y_n, bar(p_n)} : '0;
    seg_n = (st_n == TRAIN)  ? bcd(current_epoch) :
            (st_n == DONE)   ? 16'h0099 :
            (st_n == RESULT) ? bcd({1'b0, p_n}) : input_display;
    sv_n  = (st_n == IDLE) ? input_valid : 1'b1;
    nm_n  = (st_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st              <= IDLE;
      {ta_s, done_s, done_p, sub_s, sub_p} <= '0;
      dcnt            <= '0;
      hcnt            <= '0;
      acnt            <= '0;
      anim            <= '0;
      y_l             <= 1'b0;
      p_l             <= '0;
      led             <= '0;
      seg_data        <= '0;
      seg_valid       <= 1'b0;
      seg_number_mode <= 1'b0;
    end else begin
      st              <= st_n;
      ta_s            <= training_active;
      done_s          <= training_done;
      done_p          <= done_s;
      sub_s           <= btn_submit;
      sub_p           <= sub_s;
      dcnt            <= dcnt_n;
      hcnt            <= hcnt_n;
      acnt            <= acnt_n;
      anim            <= anim_n;
      y_l             <= y_n;
      p_l             <= p_n;
      led             <= led_n;
      seg_data        <= seg_n;
      seg_valid       <= sv_n;
      seg_number_mode <= nm_n;
    end
  end
endmodule
